// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor ramp controller:
//   - motor_state_t : FSM state encoding, also driven out on the 2-bit state port
//   - CLAMP_LIMIT   : magnitude limit applied to every accepted target
//   - DEFAULT_*     : default parameter values used by the controller
//   - cnt_width()   : counter width helper (always at least one bit)
// -----------------------------------------------------------------------------
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // power 0, target 0
    ST_RAMP = 2'd1,  // power moving toward the effective goal
    ST_DEAD = 2'd2,  // power held at 0 before a sign reversal
    ST_HOLD = 2'd3   // power == target != 0
  } motor_state_t;

  localparam int          CLAMP_LIMIT           = 1023;
  localparam logic [15:0] DEFAULT_STEP          = 16'd8;
  localparam int          DEFAULT_TICK_DIV      = 100000;
  localparam int          DEFAULT_DEAD_TICKS    = 50;
  localparam int          DEFAULT_TIMEOUT_TICKS = 200;

  // Width of a counter that runs 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl_if
// Groups the command handshake and the motor-side outputs of motor_ramp_ctrl.
//   cmd_valid  : a new signed target is offered on cmd_power
//   cmd_ready  : the controller accepts a target this cycle (low during estop)
//   cmd_power  : signed two's-complement target power
//   estop      : level-sensitive emergency stop
//   motor_power, state, timeout_flag : controller outputs
// Handshake: a command transfers on a clk rising edge where cmd_valid and
// cmd_ready are both high; cmd_power must be stable whenever cmd_valid is high,
// and cmd_ready never depends on cmd_valid.
// master = command source, slave = controller.
// -----------------------------------------------------------------------------
interface motor_ramp_ctrl_if #(
  parameter int SIZE = 16
);
  import motor_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_power;
  logic            estop;
  logic [SIZE-1:0] motor_power;
  logic [1:0]      state;
  logic            timeout_flag;

  modport master (
    output cmd_valid, cmd_power, estop,
    input  cmd_ready, motor_power, state, timeout_flag
  );

  modport slave (
    input  cmd_valid, cmd_power, estop,
    output cmd_ready, motor_power, state, timeout_flag
  );

endinterface

// File: rtl/motor_ramp_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider producing a one-cycle tick pulse every TICK_DIV clk
// cycles, counted from reset release (the first pulse is consumed on the
// TICK_DIV-th rising edge after release).
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   tick  : one-cycle pulse
// -----------------------------------------------------------------------------
module tick_gen
  import motor_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int               CNT_W    = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
// Slew-rate limited motor power controller. Accepts signed target commands,
// clamps them to +/-CLAMP_LIMIT and moves motor_power toward the target by at
// most STEP per tick. A sign reversal first ramps to zero, then holds zero for
// DEAD_TICKS ticks before ramping the other way. A watchdog zeroes the target
// when no command arrives for TIMEOUT_TICKS ticks while the target is nonzero.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   cmd_valid     : target offered
//   cmd_ready     : target accepted this cycle (== !estop)
//   cmd_power     : signed target
//   estop         : emergency stop, acts on the next clk edge
//   motor_power   : signed power to the driver
//   state         : FSM state (motor_state_t encoding)
//   timeout_flag  : watchdog has fired, cleared by the next accepted command
// -----------------------------------------------------------------------------
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int          SIZE          = 16,
  parameter logic [15:0] STEP          = DEFAULT_STEP,
  parameter int          TICK_DIV      = DEFAULT_TICK_DIV,
  parameter int          DEAD_TICKS    = DEFAULT_DEAD_TICKS,
  parameter int          TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SIZE-1:0] cmd_power,
  input  logic            estop,
  output logic [SIZE-1:0] motor_power,
  output logic [1:0]      state,
  output logic            timeout_flag
);

  // One extra bit of headroom so differences and steps never overflow.
  typedef logic signed [SIZE:0] wide_t;

  localparam wide_t STEP_POS  = wide_t'(STEP);
  localparam wide_t STEP_NEG  = -STEP_POS;
  localparam wide_t LIMIT_POS = wide_t'(CLAMP_LIMIT);
  localparam wide_t LIMIT_NEG = wide_t'(-CLAMP_LIMIT);

  localparam int              DEAD_W    = cnt_width(DEAD_TICKS);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);
  localparam int              WD_W      = cnt_width(TIMEOUT_TICKS);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

  logic tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  motor_state_t      state_q, state_d;
  wide_t             power_q, power_d;
  wide_t             target_q, target_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;

  wide_t cmd_wide;
  wide_t clamp_val;
  wide_t goal_w;
  wide_t diff_w;
  wide_t next_w;
  logic  reversal;

  assign cmd_ready    = !estop;
  assign motor_power  = power_q[SIZE-1:0];
  assign state        = state_q;
  assign timeout_flag = timeout_q;

  // Datapath: clamp of the offered command and the next ramp value.
  always_comb begin
    cmd_wide = $signed({cmd_power[SIZE-1], cmd_power});
    if (cmd_wide > LIMIT_POS) begin
      clamp_val = LIMIT_POS;
    end else if (cmd_wide < LIMIT_NEG) begin
      clamp_val = LIMIT_NEG;
    end else begin
      clamp_val = cmd_wide;
    end

    // While the motor still spins the "wrong" way, the goal is zero.
    reversal = (power_q != '0) && (target_q != '0) && (power_q[SIZE] != target_q[SIZE]);
    goal_w   = reversal ? '0 : target_q;
    diff_w   = goal_w - power_q;
    if (diff_w > STEP_POS) begin
      next_w = power_q + STEP_POS;
    end else if (diff_w < STEP_NEG) begin
      next_w = power_q - STEP_POS;
    end else begin
      next_w = goal_w;
    end
  end

  // FSM next-state, watchdog and command capture.
  always_comb begin
    state_d   = state_q;
    power_d   = power_q;
    target_d  = target_q;
    dead_d    = dead_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;

    if (estop) begin
      // Overrides any simultaneous command or tick.
      state_d  = ST_IDLE;
      power_d  = '0;
      target_d = '0;
      dead_d   = '0;
      wd_d     = '0;
    end else begin
      if (tick) begin
        case (state_q)
          ST_IDLE, ST_HOLD: begin
            if (power_q != target_q) state_d = ST_RAMP;
          end
          ST_RAMP: begin
            power_d = next_w;
            if (reversal && (next_w == '0)) begin
              state_d = ST_DEAD;
              dead_d  = '0;
            end else if (next_w == target_q) begin
              state_d = (target_q == '0) ? ST_IDLE : ST_HOLD;
            end
          end
          ST_DEAD: begin
            if (dead_q == DEAD_LAST) begin
              state_d = ST_RAMP;
              dead_d  = '0;
            end else begin
              dead_d = dead_q + DEAD_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase

        if (target_q != '0) begin
          if (wd_q == WD_LAST) begin
            target_d  = '0;
            timeout_d = 1'b1;
            wd_d      = '0;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end else begin
          wd_d = '0;
        end
      end

      // A command on the same edge as a watchdog expiry wins. The DEAD count
      // is left alone so a retargeted reversal still waits its full time.
      if (cmd_valid) begin
        target_d  = clamp_val;
        wd_d      = '0;
        timeout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      power_q   <= '0;
      target_q  <= '0;
      dead_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      power_q   <= power_d;
      target_q  <= target_d;
      dead_q    <= dead_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
